// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t     : sequencing FSM state encoding (RUN / WAIT / ERR)
//   FWD_*       : ALU operand forward-select codes
//   WAIT_LIMIT  : terminal value of the memory wait counter
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [3:0] WAIT_LIMIT = 4'd15;

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// Operand forwarding select for one ALU source.
//   rs_e_i                       : source register of the Execute instruction
//   rd_m_i, reg_write_m_i        : Memory-stage destination and write enable
//   rd_w_i, reg_write_w_i        : Writeback-stage destination and write enable
//   fwd_sel_o                    : 00 register file, 01 Writeback, 10 Memory
module forward_unit
  import hazard_controller_pkg::*;
(
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_m_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_sel_o
);

  // Memory stage holds the younger result, so it is checked first.
  always_comb begin
    fwd_sel_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
      fwd_sel_o = FWD_MEM;
    end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
      fwd_sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush,
// data-memory wait sequencing with a timeout into a sticky error state,
// and a saturating count of stalled fetch cycles.
//   clk, rst                        : pipeline clock (falling edge), async active-low reset
//   Rs1D, Rs2D                      : Decode sources
//   Rs1E, Rs2E, RdE                 : Execute sources / destination
//   RdM, RdW, RegWriteM, RegWriteW  : Memory / Writeback destinations and enables
//   ResultSrcE, PCSrcE              : Execute load flag, branch taken
//   MemReqM, MemReadyM              : data-memory request / acknowledge
//   ForwardAE, ForwardBE            : ALU operand selects
//   StallF/D/E/M, FlushD/E          : pipeline register hold / clear
//   MemErr, StallCount              : sticky timeout flag, stalled fetch cycles
//
// state | meaning
// RUN   | normal operation, wait counter held at 0
// WAIT  | memory access outstanding, counter advances each cycle
// ERR   | memory timed out; everything stalled until reset
module hazard_controller
  import hazard_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        ResultSrcE,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        MemErr,
  output logic [15:0] StallCount
);

  state_t      state_q;
  logic [3:0]  wait_cnt_q;
  logic        mem_err_q;
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        mem_wait;
  logic        lw_stall;
  logic        hold_all;
  logic        flush_ok;

  forward_unit u_fwd_a (
    .rs_e_i        (Rs1E),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_sel_o     (fwd_a)
  );

  forward_unit u_fwd_b (
    .rs_e_i        (Rs2E),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_sel_o     (fwd_b)
  );

  // Outputs are forced to their idle values while reset is low.
  assign ForwardAE = rst ? fwd_a : FWD_RF;
  assign ForwardBE = rst ? fwd_b : FWD_RF;

  assign mem_wait = MemReqM & ~MemReadyM;
  assign lw_stall = ResultSrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // A memory wait or timeout freezes the whole pipe and masks flushes;
  // otherwise a taken branch overrides a load-use stall.
  assign hold_all = rst & (mem_wait | (state_q == ST_ERR));
  assign flush_ok = rst & ~hold_all;

  assign StallF = hold_all | (flush_ok & lw_stall & ~PCSrcE);
  assign StallD = StallF;
  assign StallE = hold_all;
  assign StallM = hold_all;
  assign FlushD = flush_ok & PCSrcE;
  assign FlushE = flush_ok & (PCSrcE | lw_stall);

  assign MemErr     = mem_err_q;
  assign StallCount = stall_cnt_q;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 4'd0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          wait_cnt_q <= 4'd0;
          if (mem_wait) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (MemReadyM) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 4'd0;
          end else if (wait_cnt_q == WAIT_LIMIT - 4'd1) begin
            // Counter reaches the limit on this edge with no acknowledge.
            state_q    <= ST_ERR;
            wait_cnt_q <= WAIT_LIMIT;
            mem_err_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        ST_ERR: begin
          mem_err_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_RUN;
          wait_cnt_q <= 4'd0;
        end
      endcase
    end
  end

  assign stall_cnt_d = (StallF && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1
                                                             : stall_cnt_q;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  logic        clk;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr;
  logic [15:0] StallCount;

  hazard_controller dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .MemReqM    (MemReqM),
    .MemReadyM  (MemReadyM),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .MemErr     (MemErr),
    .StallCount (StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        sf, sd, se, sm, fd, fe, err;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model state: sticky error, length of the current
  // unacknowledged memory wait (0 = not waiting), stalled-fetch count.
  bit   m_err   = 0;
  int   m_wait  = 0;
  int   m_cnt   = 0;

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // Compute this cycle's expected outputs from the model, queue them,
  // then advance the model across the coming falling edge.
  task automatic commit();
    exp_t e;
    bit   mw, lw;
    e = '{fa: 2'b00, fb: 2'b00, sf: 0, sd: 0, se: 0, sm: 0, fd: 0, fe: 0,
          err: 0, cnt: 16'd0};
    if (!rst) begin
      m_err = 0; m_wait = 0; m_cnt = 0;
      sb.push_back(e);
      return;
    end
    mw = MemReqM && !MemReadyM;
    lw = ResultSrcE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    e.fa  = fwd_ref(Rs1E);
    e.fb  = fwd_ref(Rs2E);
    e.err = m_err;
    e.cnt = 16'(m_cnt);
    if (mw || m_err) begin
      e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1;
    end else if (PCSrcE) begin
      e.fd = 1; e.fe = 1;
    end else if (lw) begin
      e.sf = 1; e.sd = 1; e.fe = 1;
    end
    sb.push_back(e);
    if (e.sf && m_cnt < 65535) m_cnt++;
    if (!m_err) begin
      if (m_wait > 0) begin
        if (MemReadyM) m_wait = 0;
        else begin
          m_wait++;
          if (m_wait >= 16) m_err = 1;
        end
      end else if (mw) begin
        m_wait = 1;
      end
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle(); idle_inputs(); commit();
    end
  endtask

  task automatic do_reset();
    next_cycle(); idle_inputs(); rst = 0; commit();
    next_cycle(); idle_inputs(); commit();
  endtask

  // Monitor: every rising edge (mid-cycle) compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ForwardAE",  {14'd0, ForwardAE}, {14'd0, e.fa});
        chk("ForwardBE",  {14'd0, ForwardBE}, {14'd0, e.fb});
        chk("StallF",     {15'd0, StallF},    {15'd0, e.sf});
        chk("StallD",     {15'd0, StallD},    {15'd0, e.sd});
        chk("StallE",     {15'd0, StallE},    {15'd0, e.se});
        chk("StallM",     {15'd0, StallM},    {15'd0, e.sm});
        chk("FlushD",     {15'd0, FlushD},    {15'd0, e.fd});
        chk("FlushE",     {15'd0, FlushE},    {15'd0, e.fe});
        chk("MemErr",     {15'd0, MemErr},    {15'd0, e.err});
        chk("StallCount", StallCount,         e.cnt);
      end
    end
  end

  initial begin
    int guard;
    idle_inputs();
    rst = 0;
    do_reset();
    idle_cycles(2);

    // Forwarding priority and fall-back.
    next_cycle(); idle_inputs();
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5; commit();
    next_cycle(); RegWriteM = 0; commit();
    next_cycle(); Rs1E = 0; RdM = 0; commit();
    next_cycle(); idle_inputs(); RdM = 0; RegWriteM = 1; Rs1E = 0; commit();

    // Load-use stall, then the same with a taken branch.
    next_cycle(); idle_inputs(); ResultSrcE = 1; RdE = 7; Rs2D = 7; commit();
    next_cycle(); idle_inputs(); commit();
    next_cycle(); ResultSrcE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1; commit();
    next_cycle(); idle_inputs(); ResultSrcE = 1; RdE = 0; Rs1D = 0; commit();
    idle_cycles(1);

    // Short memory wait with a pending branch re-evaluated afterwards.
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle_inputs(); MemReqM = 1; MemReadyM = 0; PCSrcE = 1; commit();
    end
    next_cycle(); MemReadyM = 1; commit();
    idle_cycles(2);

    // Longest wait that still completes.
    for (int i = 0; i < 15; i++) begin
      next_cycle(); idle_inputs(); MemReqM = 1; MemReadyM = 0; commit();
    end
    next_cycle(); MemReadyM = 1; commit();
    idle_cycles(2);

    // Timeout into ERR, reset dropped mid-ERR, then released mid-access.
    for (int i = 0; i < 20; i++) begin
      next_cycle(); idle_inputs(); MemReqM = 1; MemReadyM = 0; commit();
    end
    next_cycle(); idle_inputs(); ResultSrcE = 1; RdE = 3; Rs1D = 3; commit();
    next_cycle(); rst = 0; MemReqM = 1; MemReadyM = 0; RdM = 4; RegWriteM = 1;
    Rs1E = 4; commit();
    next_cycle(); rst = 1; commit();
    next_cycle(); MemReadyM = 1; commit();
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      rst        = ($urandom_range(0, 63) != 0);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      ResultSrcE = 1'($urandom_range(0, 1));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      MemReqM    = ($urandom_range(0, 2) == 0);
      MemReadyM  = ($urandom_range(0, 3) != 0);
      commit();
    end

    // Saturation: hold every stall via ERR long enough to fill StallCount.
    do_reset();
    for (int i = 0; i < 65560; i++) begin
      next_cycle(); idle_inputs(); MemReqM = 1; MemReadyM = 0; commit();
    end
    idle_cycles(4);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #1;
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
